// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers, decoding its own funct group.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO/MFHI/MFLO are single cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       function_field,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             f_arith, f_mfhi, f_mflo, f_mthi, f_mtlo, f_unit;
    logic             op_signed;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign f_arith = (function_field == F_MULT) || (function_field == F_MULTU) ||
                     (function_field == F_DIV)  || (function_field == F_DIVU);
    assign f_mfhi  = (function_field == F_MFHI);
    assign f_mflo  = (function_field == F_MFLO);
    assign f_mthi  = (function_field == F_MTHI);
    assign f_mtlo  = (function_field == F_MTLO);
    assign f_unit  = f_arith || f_mfhi || f_mflo || f_mthi || f_mtlo;

    // Even funct codes in the arithmetic group are the signed variants.
    assign op_signed = ~function_field[0];
    assign a_abs = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign b_abs = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    assign mul_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign rem_sh  = {acc_q, low_q[WIDTH-1]};

    assign prod     = {acc_q, low_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -low_q : low_q;
    assign rem_fix  = rneg_q ? -acc_q : acc_q;

    assign busy  = (state_q != S_IDLE);
    assign stall = start && f_unit && busy;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;

    always_comb begin
        result = '0;
        if (start && f_mfhi) begin
            result = hi_q;
        end else if (start && f_mflo) begin
            result = lo_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        opa_d    = opa_q;
        b_d      = b_q;
        acc_d    = acc_q;
        low_d    = low_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && f_arith) begin
                    state_d  = S_RUN;
                    cnt_d    = CW'(WIDTH);
                    is_div_d = function_field[1];
                    neg_d    = op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    rneg_d   = op_signed && operand_a[WIDTH-1];
                    div0_d   = (operand_b == '0);
                    opa_d    = operand_a;
                    b_d      = b_abs;
                    acc_d    = '0;
                    low_d    = a_abs;
                end else if (start && f_mthi) begin
                    hi_d = operand_a;
                end else if (start && f_mtlo) begin
                    lo_d = operand_a;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    // Restoring step: the remainder fits WIDTH bits whenever the subtract is taken.
                    if (rem_sh >= {1'b0, b_q}) begin
                        acc_d = rem_sh[WIDTH-1:0] - b_q;
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            opa_q    <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            opa_q    <= opa_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random bench for muldiv_sequencer: expected HI/LO pairs are queued
// when an operation is launched and popped when done pulses.
module tb_muldiv_sequencer;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk;
    logic         rst;
    logic         start;
    logic [5:0]   function_field;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_hi, m_lo;
    int checks;
    int errors;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .function_field(function_field),
        .operand_a(operand_a), .operand_b(operand_b), .result(result),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] p, q64, r64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = '0;
        case (f)
            F_MULT:  begin sq = sa * sb; p = sq; end
            F_MULTU: p = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == '0) p = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb; sr = sa % sb;
                    q64 = sq; r64 = sr;
                    p = {r64[31:0], q64[31:0]};
                end
            end
            F_DIVU: begin
                if (b == '0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; function_field = f; operand_a = a; operand_b = b;
        exp_q.push_back(model(f, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        bit seen;
        logic [2*W-1:0] e;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(W + 1));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
        chk({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
        m_hi = e[2*W-1:W];
        m_lo = e[W-1:0];
    endtask

    initial begin
        int dcount;
        logic [5:0] rf;
        logic [W-1:0] ra, rb;
        checks = 0; errors = 0;
        m_hi = '0; m_lo = '0;
        rst = 1'b1; start = 1'b0; function_field = '0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rst = 1'b0;

        // MULTU max*max, then signed multiplies including MIN*MIN
        launch(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max");
        launch(F_MULT, -32'sd3, 32'd7);
        wait_done("mult_neg");
        launch(F_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min");

        // Divides: signed negative, unsigned, MIN/-1, both divide-by-zero flavours
        launch(F_DIV, -32'sd7, 32'd2);
        wait_done("div_neg");
        launch(F_DIVU, 32'd7, 32'd2);
        wait_done("divu");
        launch(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min_m1");
        launch(F_DIV, -32'sd8, 32'd0);
        wait_done("div_zero_s");
        launch(F_DIVU, 32'd5, 32'd0);
        wait_done("divu_zero");
        start = 1'b1; function_field = F_MFLO;
        #1;
        chk("mflo_after_div0", 64'(result), 64'hFFFF_FFFF);
        chk("mflo_no_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("result_idle_zero", 64'(result), 64'd0);

        // MFHI held while a multiply runs: stalls, shows old hi, then new hi in done cycle
        launch(F_MULT, 32'd12345, -32'sd2);
        start = 1'b1; function_field = F_MFHI;
        #1;
        chk("mfhi_stall", 64'(stall), 64'd1);
        chk("mfhi_old", 64'(result), 64'(m_hi));
        wait_done("mult_held_mfhi");
        chk("mfhi_new", 64'(result), 64'(m_hi));
        chk("mfhi_release", 64'(stall), 64'd0);
        start = 1'b0;

        // MTHI held while busy must not write hi
        launch(F_DIVU, 32'd1000, 32'd33);
        start = 1'b1; function_field = F_MTHI; operand_a = 32'hDEAD_BEEF;
        #1;
        chk("mthi_stall", 64'(stall), 64'd1);
        wait_done("divu_held_mthi");
        start = 1'b0;

        // MULTU held during another MULTU: no restart, then back-to-back in the done cycle
        launch(F_MULTU, 32'd5, 32'd6);
        start = 1'b1; function_field = F_MULTU; operand_a = 32'd7; operand_b = 32'd9;
        #1;
        chk("hold_stall", 64'(stall), 64'd1);
        wait_done("multu_first");
        exp_q.push_back(model(F_MULTU, 32'd7, 32'd9));
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done("multu_b2b");

        // Non-unit funct is ignored
        start = 1'b1; function_field = 6'b100000; operand_a = 32'h55AA_55AA;
        #1;
        chk("other_no_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("other_no_busy", 64'(busy), 64'd0);
        chk("other_hi", 64'(hi), 64'(m_hi));
        chk("other_lo", 64'(lo), 64'(m_lo));

        // Random operations
        for (int i = 0; i < 6; i++) begin
            rf = F_MULT + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            launch(rf, ra, rb);
            wait_done("random");
        end

        // Reset at edge 10 of a divide aborts it with no done pulse
        launch(F_DIV, -32'sd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);

        // MTLO then MFLO
        start = 1'b1; function_field = F_MTLO; operand_a = 32'h0000_1234;
        @(posedge clk); #1;
        function_field = F_MFLO;
        #1;
        chk("mtlo_lo", 64'(lo), 64'h1234);
        chk("mtlo_mflo", 64'(result), 64'h1234);
        chk("mtlo_no_done", 64'(done), 64'd0);
        chk("mtlo_hi_kept", 64'(hi), 64'd0);
        start = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
